// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU/immediate selectors and the ID/EX register layout.
package riscv_pkg;

    localparam int REG_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] pc;
        logic [REG_W-1:0] rs1_data;
        logic [REG_W-1:0] rs2_data;
        logic [REG_W-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        alu_op_t          alu_op;
        logic             alu_src_imm;
        logic             alu_src_pc;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic             branch;
        logic             jump;
        logic             jalr;
        logic [2:0]       funct3;
        logic             illegal;
    } id_ex_t;

    // alt selects SUB/SRA (instr[30]) where the encoding allows it.
    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate extraction for the five RV32I formats, sign-extended to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_type_t       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        case (imm_type)
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            stall_in,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output alu_op_t         ex_alu_op,
    output logic            ex_alu_src_imm,
    output logic            ex_alu_src_pc,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    imm_type_t       imm_type;
    logic [XLEN-1:0] imm_val;
    logic            rs1_used, rs2_used, dec_illegal;
    alu_op_t         dec_alu;
    logic            d_src_imm, d_src_pc, d_mem_read, d_mem_write, d_reg_write;
    logic            d_mem_to_reg, d_branch, d_jump, d_jalr;
    id_ex_t          cap, id_ex_p1;

    assign opcode   = id_instr[6:0];
    assign f3       = id_instr[14:12];
    assign f7       = id_instr[31:25];
    assign rd       = id_instr[11:7];
    assign rs1_addr = id_instr[19:15];
    assign rs2_addr = id_instr[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (id_instr),
        .imm_type (imm_type),
        .imm      (imm_val)
    );

    always_comb begin
        imm_type     = IMM_I;
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        dec_illegal  = 1'b0;
        dec_alu      = ALU_ADD;
        d_src_imm    = 1'b0;
        d_src_pc     = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_reg_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_jalr       = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_type = IMM_U; rs1_used = 1'b0; dec_alu = ALU_PASS_B;
                d_src_imm = 1'b1; d_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type = IMM_U; rs1_used = 1'b0;
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm_type = IMM_J; rs1_used = 1'b0;
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_jump = 1'b1; d_reg_write = 1'b1;
            end
            OPC_JALR: begin
                d_src_imm = 1'b1; d_jump = 1'b1; d_jalr = 1'b1; d_reg_write = 1'b1;
                dec_illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_type = IMM_B; rs2_used = 1'b1; dec_alu = ALU_SUB; d_branch = 1'b1;
                dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_src_imm = 1'b1; d_mem_read = 1'b1; d_mem_to_reg = 1'b1; d_reg_write = 1'b1;
                dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                imm_type = IMM_S; rs2_used = 1'b1; d_src_imm = 1'b1; d_mem_write = 1'b1;
                dec_illegal = f3[2] || (f3 == 3'b011);
            end
            OPC_OPIMM: begin
                dec_alu   = alu_from_funct(f3, (f3 == 3'b101) && id_instr[30]);
                d_src_imm = 1'b1; d_reg_write = 1'b1;
                // Only the shift encodings constrain the upper immediate bits.
                if (f3 == 3'b001)
                    dec_illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                rs2_used    = 1'b1;
                dec_alu     = alu_from_funct(f3, id_instr[30]);
                d_reg_write = 1'b1;
                dec_illegal = !((f7 == 7'b0000000) ||
                                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_FENCE: ;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            d_mem_read   = 1'b0;
            d_mem_write  = 1'b0;
            d_reg_write  = 1'b0;
            d_mem_to_reg = 1'b0;
            d_branch     = 1'b0;
            d_jump       = 1'b0;
            d_jalr       = 1'b0;
        end
    end

    always_comb begin
        cap             = '0;
        cap.valid       = id_valid;
        cap.pc          = id_pc;
        cap.rs1_data    = rs1_data;
        cap.rs2_data    = rs2_data;
        cap.imm         = imm_val;
        cap.rs1         = rs1_addr;
        cap.rs2         = rs2_addr;
        cap.rd          = rd;
        cap.alu_op      = dec_alu;
        cap.funct3      = f3;
        cap.alu_src_imm = id_valid & d_src_imm;
        cap.alu_src_pc  = id_valid & d_src_pc;
        cap.mem_read    = id_valid & d_mem_read;
        cap.mem_write   = id_valid & d_mem_write;
        cap.reg_write   = id_valid & d_reg_write & (rd != 5'd0);
        cap.mem_to_reg  = id_valid & d_mem_to_reg;
        cap.branch      = id_valid & d_branch;
        cap.jump        = id_valid & d_jump;
        cap.jalr        = id_valid & d_jalr;
        cap.illegal     = id_valid & dec_illegal;
    end

    // Load in EX whose destination feeds a source read by the instruction in ID.
    assign hazard_stall = !flush && id_valid && id_ex_p1.valid && id_ex_p1.mem_read &&
                          (id_ex_p1.rd != 5'd0) &&
                          ((rs1_used && (id_ex_p1.rd == rs1_addr)) ||
                           (rs2_used && (id_ex_p1.rd == rs2_addr)));

    // ID/EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_p1    <= '0;
            id_ex_p1.pc <= RESET_PC;
        end else if (flush) begin
            id_ex_p1 <= '0;
        end else if (stall_in) begin
            id_ex_p1 <= id_ex_p1;
        end else if (hazard_stall) begin
            id_ex_p1 <= '0;
        end else begin
            id_ex_p1 <= cap;
        end
    end

    assign ex_valid       = id_ex_p1.valid;
    assign ex_pc          = id_ex_p1.pc;
    assign ex_rs1_data    = id_ex_p1.rs1_data;
    assign ex_rs2_data    = id_ex_p1.rs2_data;
    assign ex_imm         = id_ex_p1.imm;
    assign ex_rs1         = id_ex_p1.rs1;
    assign ex_rs2         = id_ex_p1.rs2;
    assign ex_rd          = id_ex_p1.rd;
    assign ex_alu_op      = id_ex_p1.alu_op;
    assign ex_alu_src_imm = id_ex_p1.alu_src_imm;
    assign ex_alu_src_pc  = id_ex_p1.alu_src_pc;
    assign ex_mem_read    = id_ex_p1.mem_read;
    assign ex_mem_write   = id_ex_p1.mem_write;
    assign ex_reg_write   = id_ex_p1.reg_write;
    assign ex_mem_to_reg  = id_ex_p1.mem_to_reg;
    assign ex_branch      = id_ex_p1.branch;
    assign ex_jump        = id_ex_p1.jump;
    assign ex_jalr        = id_ex_p1.jalr;
    assign ex_funct3      = id_ex_p1.funct3;
    assign ex_illegal     = id_ex_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push hand-computed expectations, monitors compare.
module tb_id_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_instr = '0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    alu_op_t     ex_alu_op;
    logic        ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_mem_to_reg, ex_branch, ex_jump, ex_jalr, ex_illegal;
    logic [2:0]  ex_funct3;

    // Register file stand-in: read data encodes the address so operand routing is visible.
    assign rs1_data = 32'h100 + {27'd0, rs1_addr};
    assign rs2_data = 32'h200 + {27'd0, rs2_addr};

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3),
        .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        alu_op_t     alu;
        logic        rw, mr, mw, simm, ill;
        logic [2:0]  f3;
        logic [31:0] r1d;
    } exp_t;

    exp_t ex_q[$];
    logic hz_q[$];
    int   total = 0;
    int   bad = 0;
    int   ex_idx = 0;
    int   hz_idx = 0;

    function automatic exp_t mk(logic v, logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [31:0] imm, alu_op_t alu, logic rw,
                                logic mr, logic mw, logic simm, logic ill, logic [2:0] f3,
                                logic [31:0] r1d);
        exp_t e;
        e.valid = v; e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu = alu;
        e.rw = rw; e.mr = mr; e.mw = mw; e.simm = simm; e.ill = ill; e.f3 = f3; e.r1d = r1d;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(0, 32'h0, 0, 0, 0, 32'h0, ALU_ADD, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    endfunction
    function automatic exp_t rst_rec();
        return mk(0, RPC, 0, 0, 0, 32'h0, ALU_ADD, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    endfunction
    function automatic exp_t addi_rec(logic [31:0] pc);   // addi x1,x0,5
        return mk(1, pc, 1, 0, 5, 32'h5, ALU_ADD, 1, 0, 0, 1, 0, 3'b000, 32'h100);
    endfunction
    function automatic exp_t lw_rec(logic [31:0] pc);     // lw x2,0(x1)
        return mk(1, pc, 2, 1, 0, 32'h0, ALU_ADD, 1, 1, 0, 1, 0, 3'b010, 32'h101);
    endfunction
    function automatic exp_t add_rec(logic [31:0] pc);    // add x3,x2,x2
        return mk(1, pc, 3, 2, 2, 32'h2, ALU_ADD, 1, 0, 0, 0, 0, 3'b000, 32'h102);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs are applied 2 time units after a rising edge; expectations describe that cycle.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic st, input logic fl, input logic hz, input exp_t e);
        id_valid = v; id_pc = pc; id_instr = instr; stall_in = st; flush = fl;
        hz_q.push_back(hz);
        ex_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (hz_q.size() > 0) begin
            chk($sformatf("c%0d hazard_stall", hz_idx), {31'd0, hazard_stall}, {31'd0, hz_q.pop_front()});
            hz_idx++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                exp_t e;
                string c;
                e = ex_q.pop_front();
                c = $sformatf("c%0d", ex_idx);
                chk({c, " ex_valid"},       {31'd0, ex_valid},       {31'd0, e.valid});
                chk({c, " ex_pc"},          ex_pc,                   e.pc);
                chk({c, " ex_rd"},          {27'd0, ex_rd},          {27'd0, e.rd});
                chk({c, " ex_rs1"},         {27'd0, ex_rs1},         {27'd0, e.rs1});
                chk({c, " ex_rs2"},         {27'd0, ex_rs2},         {27'd0, e.rs2});
                chk({c, " ex_imm"},         ex_imm,                  e.imm);
                chk({c, " ex_alu_op"},      32'(ex_alu_op),          32'(e.alu));
                chk({c, " ex_reg_write"},   {31'd0, ex_reg_write},   {31'd0, e.rw});
                chk({c, " ex_mem_read"},    {31'd0, ex_mem_read},    {31'd0, e.mr});
                chk({c, " ex_mem_write"},   {31'd0, ex_mem_write},   {31'd0, e.mw});
                chk({c, " ex_alu_src_imm"}, {31'd0, ex_alu_src_imm}, {31'd0, e.simm});
                chk({c, " ex_illegal"},     {31'd0, ex_illegal},     {31'd0, e.ill});
                chk({c, " ex_funct3"},      {29'd0, ex_funct3},      {29'd0, e.f3});
                chk({c, " ex_rs1_data"},    ex_rs1_data,             e.r1d);
                ex_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #2;
        cyc(0, 32'h0, 32'h0, 0, 0, 0, rst_rec());
        cyc(0, 32'h0, 32'h0, 0, 0, 0, rst_rec());
        rst_n = 1'b1;
        cyc(1, 32'h100, 32'h00500093, 0, 0, 0, addi_rec(32'h100));
        cyc(1, 32'h104, 32'hFE50AE23, 0, 0, 0,
            mk(1, 32'h104, 28, 1, 5, 32'hFFFF_FFFC, ALU_ADD, 0, 0, 1, 1, 0, 3'b010, 32'h101));
        // Load-use: one bubble, then the dependent add captures.
        cyc(1, 32'h108, 32'h0000A103, 0, 0, 0, lw_rec(32'h108));
        cyc(1, 32'h10C, 32'h002101B3, 0, 0, 1, bubble());
        cyc(1, 32'h10C, 32'h002101B3, 0, 0, 0, add_rec(32'h10C));
        // Flush with stall_in: flush wins and masks the hazard.
        cyc(1, 32'h110, 32'h0000A103, 0, 0, 0, lw_rec(32'h110));
        cyc(1, 32'h114, 32'h002101B3, 1, 1, 0, bubble());
        // stall_in alone holds ID/EX for 3 cycles.
        cyc(1, 32'h118, 32'h00500093, 0, 0, 0, addi_rec(32'h118));
        cyc(1, 32'h11C, 32'hFE50AE23, 1, 0, 0, addi_rec(32'h118));
        cyc(1, 32'h11C, 32'hFE50AE23, 1, 0, 0, addi_rec(32'h118));
        cyc(1, 32'h11C, 32'hFE50AE23, 1, 0, 0, addi_rec(32'h118));
        // Hazard still reported while stalled on a held load.
        cyc(1, 32'h120, 32'h0000A103, 0, 0, 0, lw_rec(32'h120));
        cyc(1, 32'h124, 32'h002101B3, 1, 0, 1, lw_rec(32'h120));
        cyc(1, 32'h124, 32'h002101B3, 0, 0, 1, bubble());
        cyc(1, 32'h124, 32'h002101B3, 0, 0, 0, add_rec(32'h124));
        cyc(1, 32'h128, 32'hFFFFFFFF, 0, 0, 0,
            mk(1, 32'h128, 31, 31, 31, 32'hFFFF_FFFF, ALU_ADD, 0, 0, 0, 0, 1, 3'b111, 32'h11F));
        cyc(1, 32'h12C, 32'h00708013, 0, 0, 0,
            mk(1, 32'h12C, 0, 1, 7, 32'h7, ALU_ADD, 0, 0, 0, 1, 0, 3'b000, 32'h101));
        cyc(1, 32'h130, 32'h0000A003, 0, 0, 0,
            mk(1, 32'h130, 0, 1, 0, 32'h0, ALU_ADD, 0, 1, 0, 1, 0, 3'b010, 32'h101));
        cyc(1, 32'h134, 32'h000001B3, 0, 0, 0,
            mk(1, 32'h134, 3, 0, 0, 32'h0, ALU_ADD, 1, 0, 0, 0, 0, 3'b000, 32'h100));
        cyc(1, 32'h138, 32'h123452B7, 0, 0, 0,
            mk(1, 32'h138, 5, 8, 3, 32'h1234_5000, ALU_PASS_B, 1, 0, 0, 1, 0, 3'b101, 32'h108));
        // Store data (rs2) dependent on the load.
        cyc(1, 32'h13C, 32'h0000A103, 0, 0, 0, lw_rec(32'h13C));
        cyc(1, 32'h140, 32'h0020A023, 0, 0, 1, bubble());
        cyc(1, 32'h140, 32'h0020A023, 0, 0, 0,
            mk(1, 32'h140, 0, 1, 2, 32'h0, ALU_ADD, 0, 0, 1, 1, 0, 3'b010, 32'h101));
        cyc(1, 32'h144, 32'h00500093, 0, 0, 0, addi_rec(32'h144));

        // Asynchronous reset mid-cycle while ex_valid=1.
        id_valid = 0; id_pc = 32'h0; id_instr = 32'h0; stall_in = 0; flush = 0;
        hz_q.push_back(1'b0);
        ex_q.push_back(rst_rec());
        #1;
        rst_n = 1'b0;
        #1;
        chk("async ex_valid",     {31'd0, ex_valid},     32'd0);
        chk("async ex_pc",        ex_pc,                 RPC);
        chk("async ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("async ex_imm",       ex_imm,                32'd0);
        chk("async ex_rd",        {27'd0, ex_rd},        32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1, 32'h148, 32'h00500093, 0, 1, 0, bubble());

        for (int i = 0; i < 5 && (ex_q.size() > 0 || hz_q.size() > 0); i++) @(posedge clk);
        #3;
        total++;
        if (ex_q.size() != 0 || hz_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", ex_q.size() + hz_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. Takes the IF/ID instruction and PC, drives the register-file read addresses, and combines the returned operands with decoded control and the sign-extended immediate. Detects load-use hazards and registers everything into the ID/EX pipeline register that feeds the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_pc  in  XLEN  PC of the instruction being decoded.
- id_instr  in  32  instruction word.
- rs1_addr, rs2_addr  out  5  register-file read addresses, combinational from id_instr[19:15] and id_instr[24:20].
- rs1_data, rs2_data  in  XLEN  register-file read data, combinational; includes write bypass.
- stall_in  in  1  execute stage or later cannot accept; hold ID/EX.
- flush  in  1  branch or jump redirect; kill the instruction in ID.
- hazard_stall  out  1  combinational load-use stall; IF and IF/ID must hold.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  XLEN.
- ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN.
- ex_rs1, ex_rs2, ex_rd  out  5.
- ex_alu_op  out  alu_op_t  ALU operation.
- ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_jalr  out  1 each.
- ex_funct3  out  3  branch and load/store size qualifier.
- ex_illegal  out  1  unsupported opcode or funct.

## Operation
- Decode covers the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE. FENCE decodes as a NOP. Any other opcode sets illegal.
- Illegal instructions advance down the pipe with ex_illegal=1 and all side-effect controls at 0: reg_write, mem_read, mem_write, branch and jump.
- Immediate formats, each sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- rs1 is "used" for every opcode except LUI, AUIPC and JAL. rs2 is "used" for OP, STORE and BRANCH only.
- hazard_stall is asserted when all of the following hold:
  - id_valid & ex_valid & ex_mem_read & (ex_rd != 0);
  - and either (rs1 used & ex_rd == rs1) or (rs2 used & ex_rd == rs2).
- reg_write is forced to 0 when rd = x0.
- ID/EX update priority, evaluated at each rising edge:
  1. flush: load a bubble. ex_valid=0 and all controls 0; data fields are don't-care but are driven to 0.
  2. stall_in: hold every ID/EX field unchanged.
  3. hazard_stall: load a bubble. The instruction stays in IF/ID because upstream holds.
  4. otherwise: capture the decode of id_instr. ex_valid=id_valid; controls are gated by id_valid.
- hazard_stall is masked to 0 while flush=1.
- While stall_in=1, hazard_stall still reflects the current ID/EX contents.

## Timing
- Decode latency is 1 cycle: the instruction present in ID at edge N appears on ex_* after edge N.
- A load-use hazard inserts exactly 1 bubble. On the next cycle the load has left EX, so hazard_stall deasserts and the dependent instruction captures normally. Its operand arrives via forwarding.
- Register reads are combinational in the same cycle as decode. WB-to-ID same-cycle writes are seen through the register file's bypass, so no extra logic is needed here.
- Reset (asynchronous assert, synchronous-safe deassert):
  - all ex_* outputs 0;
  - ex_pc = RESET_PC;
  - hazard_stall = 0 while ex_valid = 0.
- Reset asserted mid-stall or mid-flush overrides both and yields a bubble on the next edge after release.

## Structure
- riscv_pkg holds:
  - opcode localparams;
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B;
  - imm_type_t enum: I, S, B, U, J;
  - the id_ex_t packed struct.
- One sub-module, imm_gen: combinational (instr, imm_type) -> XLEN immediate.
- Decode logic and the ID/EX register live in id_stage. The ID/EX register is a single always_ff on the id_ex_t struct.

## Test plan
- addi x1,x0,5 (0x00500093) with id_valid=1 -> after 1 edge:
  - ex_imm=5, ex_rd=1, ex_rs1=0;
  - ex_reg_write=1, ex_alu_src_imm=1, ex_alu_op=ADD, ex_valid=1.
- sw x5,-4(x1) (0xFE50AE23) -> ex_imm=0xFFFFFFFC, ex_mem_write=1, ex_reg_write=0, ex_rs1=1, ex_rs2=5, ex_funct3=3'b010.
- lw x2,0(x1) (0x0000A103) followed by add x3,x2,x2 (0x002101B3):
  - hazard_stall=1 for 1 cycle;
  - ID/EX shows 1 bubble (ex_valid=0);
  - then the add appears with ex_rd=3 and ex_alu_op=ADD.
- flush and stall_in asserted together while the add is in ID -> bubble captured and hazard_stall=0. stall_in alone for 3 cycles -> ex_* held constant for 3 cycles.
- id_instr=0xFFFFFFFF -> ex_illegal=1, ex_reg_write=0, ex_mem_write=0, ex_valid=1.
- rst_n dropped asynchronously mid-cycle while ex_valid=1 -> all ex_* outputs 0 immediately, without waiting for a clk edge, and ex_pc=RESET_PC.
